e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multi-cycle multiply/divide unit. It is the HI/LO-writing counterpart to the single-cycle E-stage ALU.
- Accepts a one-cycle start pulse with operands, stays busy for a fixed latency, then commits results to the HI/LO registers.
- The hazard unit stalls D-stage on `busy`, or on a start plus a pending mult/div op.
- The W-side reads HI/LO combinationally for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request qualifier; mdu_op is sampled only when start=1
- mdu_op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- A  input  32  rs operand, already forwarded
- B  input  32  rt operand, already forwarded
- busy  output  1  high while a mult/div is in flight
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, latched op cleared. Applies immediately, including mid-operation; any in-flight result is discarded.
- FSM has two states:
  - IDLE -> RUN when start=1 and mdu_op is in {001..100}.
  - RUN -> IDLE when the counter reaches 1.
- On start in IDLE: latch A, B and op. Load counter with MULT_CYCLES or DIV_CYCLES. busy=1 from the next edge.
- busy is a registered output. For a start at edge t, busy is high for edges t+1 .. t+N, where N is the op latency.
  - hi/lo update at edge t+N, on the same edge busy falls.
  - Results are visible the cycle after busy drops.
- hi/lo hold their old values throughout RUN.
- mult: {hi,lo} = signed(A) * signed(B), full 64-bit product.
- multu: unsigned 64-bit product.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (A).
  - Special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0, div or divu): runs the full DIV_CYCLES, then hi/lo remain unchanged.
- mthi / mtlo in IDLE: hi<=A (or lo<=A) at the same edge; busy stays 0.
- start while busy=1: ignored entirely, whatever the op. Preventing this is the hazard unit's job.
- start with op 000 or 111: no effect.
- Latched operands are used for the result. A and B may change after the start cycle without affecting the result.
- Back-to-back: a start on the first cycle where busy=0 is accepted and returns to RUN.
- mthi in the same cycle HI commits from RUN is impossible, because start is ignored while busy=1.

Decomposition:
- Shared package or header holds:
  - MDU op encodings: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - Default latencies.
- The same encodings are used by the controller and the hazard unit.
- The FSM/counter stays inline.
- One combinational sub-module, e_mdu_calc, computes the 64-bit {hi,lo} result from the latched op, A and B.
  - It flags div-by-zero.
  - It enables independent verification of the arithmetic.

Test Plan:
- Reset mid-op:
  - Stimulus: reset=0 asserted 3 cycles into a div.
  - Required response: busy=0 and hi=lo=0 immediately (asynchronously); no commit afterwards.
- Signed mult:
  - Stimulus: start, mult, A=0xFFFFFFFE (-2), B=3.
  - Required response: busy high for exactly 5 edges; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned mult:
  - Stimulus: multu, A=B=0xFFFFFFFF.
  - Required response: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- Signed div:
  - Stimulus: div, A=-7 (0xFFFFFFF9), B=2.
  - Required response: busy high for 10 edges; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide edge cases:
  - 0x80000000 / -1 -> lo=0x80000000, hi=0.
  - divu 10 / 0 with prior hi=0x11, lo=0x22 -> hi/lo unchanged after 10 cycles.
- Protocol checks:
  - mtlo A=0x1234 in IDLE -> lo=0x1234 next edge, busy stays 0.
  - A mult start while busy is ignored; the original result commits.
  - A new start on the first non-busy cycle is accepted.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// controller states and default latencies (also used by the hazard unit).
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for multiple cycles and make it busy.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational arithmetic core: 64-bit {hi,lo} result for the latched
// mult/multu/div/divu operation, plus a divide-by-zero flag.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_dz
);

  logic               w_b_zero;
  logic               w_ovf;
  logic [31:0]        w_div_b;
  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic [31:0]        w_uquo;
  logic [31:0]        w_urem;

  assign w_b_zero = (i_b == 32'd0);
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  // Dividing by 1 instead yields exactly the required 0x80000000 / 0 for the
  // overflow case and keeps the divider away from zero divisors.
  assign w_div_b  = (w_b_zero || w_ovf) ? 32'd1 : i_b;

  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};
  assign w_squo  = $signed(i_a) / $signed(w_div_b);
  assign w_srem  = $signed(i_a) % $signed(w_div_b);
  assign w_uquo  = i_a / w_div_b;
  assign w_urem  = i_a % w_div_b;

  // Result select by op.
  always_comb begin
    o_res = 64'd0;
    case (i_op)
      MDU_MULT:  o_res = w_sprod;
      MDU_MULTU: o_res = w_uprod;
      MDU_DIV:   o_res = {w_srem, w_squo};
      MDU_DIVU:  o_res = {w_urem, w_uquo};
      default:   o_res = 64'd0;
    endcase
  end

  assign o_dz = ((i_op == MDU_DIV) || (i_op == MDU_DIVU)) && w_b_zero;

endmodule

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit with architectural HI/LO.
// Fixed-latency busy window; results commit on the edge busy falls.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_lat;
  logic [2:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             w_accept;
  logic             w_last;
  logic             w_commit;
  logic             w_mthi;
  logic             w_mtlo;
  logic [63:0]      w_res;
  logic             w_dz;

  e_mdu_calc u_calc (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_res (w_res),
    .o_dz  (w_dz)
  );

  assign w_last = (r_cnt == CNT_W'(1));
  assign w_lat  = is_mult_op(mdu_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  // State register; busy is registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_RUN;
        else          w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_IDLE;
        else        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: request acceptance, moves to HI/LO, and commit strobe.
  always_comb begin
    w_accept = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = is_long_op(mdu_op);
          w_mthi   = (mdu_op == MDU_MTHI);
          w_mtlo   = (mdu_op == MDU_MTLO);
        end else begin
          w_accept = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_last) w_commit = !w_dz;
        else        w_commit = 1'b0;
      end
      default: w_commit = 1'b0;
    endcase
  end

  // Operand/op latch and latency counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_op  <= MDU_NONE;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
    end else if (w_accept) begin
      r_cnt <= w_lat;
      r_op  <= mdu_op;
      r_a   <= A;
      r_b   <= B;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Architectural HI/LO: commit from RUN, or direct moves in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= w_res[63:32];
      r_lo <= w_res[31:0];
    end else begin
      if (w_mthi) r_hi <= A;
      else        r_hi <= r_hi;
      if (w_mtlo) r_lo <= A;
      else        r_lo <= r_lo;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: latency, arithmetic, divide edge
// cases, HI/LO moves, busy-time protocol and asynchronous reset.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks;
  int          n_fails;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; operands are scrambled afterwards.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    tick();
    start  = 1'b0;
    mdu_op = 3'b000;
    A      = 32'hDEAD_BEEF;
    B      = 32'h0BAD_F00D;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start_op(op, a, b);
    check_eq({tag, "_hold_hi"}, 64'(hi), 64'(m_hi));
    wait_idle(n);
    check_eq({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fails  = 0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    reset    = 1'b0;
    start    = 1'b0;
    mdu_op   = 3'b000;
    A        = 32'd0;
    B        = 32'd0;
    #2;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    start_op(MDU_MTLO, 32'h0000_1234, 32'd0);
    check_eq("mtlo_lo", 64'(lo), 64'h1234);
    check_eq("mtlo_busy", 64'(busy), 64'd0);
    m_lo = 32'h0000_1234;
    start_op(MDU_MTHI, 32'h0000_55AA, 32'd0);
    check_eq("mthi_hi", 64'(hi), 64'h55AA);
    check_eq("mthi_lo_kept", 64'(lo), 64'h1234);
    m_hi = 32'h0000_55AA;

    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E);
    run_op("divu_big", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);

    // Divide by zero leaves HI/LO untouched.
    start_op(MDU_MTHI, 32'h11, 32'd0);
    start_op(MDU_MTLO, 32'h22, 32'd0);
    m_hi = 32'h11;
    m_lo = 32'h22;
    run_op("divu_by0", MDU_DIVU, 32'd10, 32'd0, 10, 32'h11, 32'h22);
    run_op("div_by0", MDU_DIV, 32'hFFFF_FFF0, 32'd0, 10, 32'h11, 32'h22);

    // Starts while busy are ignored, whatever the op.
    start_op(MDU_MULT, 32'd6, 32'd7);
    start_op(MDU_MULT, 32'd100, 32'd100);
    start_op(MDU_MTHI, 32'hBAD0_0BAD, 32'd0);
    wait_idle(n);
    check_eq("busy_ign_cycles", 64'(n + 2), 64'd5);
    check_eq("busy_ign_hi", 64'(hi), 64'd0);
    check_eq("busy_ign_lo", 64'(lo), 64'd42);
    m_hi = 32'd0;
    m_lo = 32'd42;

    // Back-to-back on the first non-busy cycle.
    run_op("b2b_multu", MDU_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    start_op(3'b111, 32'hFFFF, 32'hFFFF);
    check_eq("op7_busy", 64'(busy), 64'd0);
    check_eq("op7_hi", 64'(hi), 64'(m_hi));
    start_op(3'b000, 32'hFFFF, 32'hFFFF);
    check_eq("op0_busy", 64'(busy), 64'd0);
    check_eq("op0_lo", 64'(lo), 64'(m_lo));

    // Asynchronous reset three cycles into a divide.
    start_op(MDU_MTHI, 32'h99, 32'd0);
    start_op(MDU_MTLO, 32'h88, 32'd0);
    start_op(MDU_DIV, 32'd100, 32'd3);
    tick();
    tick();
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    check_eq("async_rst_hi", 64'(hi), 64'd0);
    check_eq("async_rst_lo", 64'(lo), 64'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    check_eq("post_rst_hi", 64'(hi), 64'd0);
    check_eq("post_rst_lo", 64'(lo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
